// File: rtl/xadc_pkg.sv
// Shared types and constants for the XADC DRP read sequencer.
package xadc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_A,
        S_WAIT_A,
        S_REQ_B,
        S_WAIT_B,
        S_DONE
    } state_t;

    localparam logic [6:0] XADC_VAUX3_ADDR  = 7'h13;
    localparam logic [6:0] XADC_VAUX11_ADDR = 7'h1B;
    localparam int unsigned ADC_W = 12;

endpackage

// File: rtl/drp_read_port.sv
// Single-request DRP read port: den pulse, drdy wait with timeout, data capture.
// done/err are registered strobes, so the caller sees them the cycle after drdy/expiry.
module drp_read_port
    import xadc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 63
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             drdy,
    input  logic [15:0]      do_in,
    output logic             den,
    output logic             done,
    output logic             err,
    output logic [ADC_W-1:0] data
);

    localparam logic [5:0] TMO = 6'(TIMEOUT);

    logic       pending;
    logic [5:0] cnt;
    logic       unused_low;

    assign den        = start;
    assign unused_low = ^do_in[3:0];

    // drdy is checked before the limit so a response on the final cycle still counts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            cnt     <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            data    <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (start) begin
                pending <= 1'b1;
                cnt     <= '0;
            end else if (pending) begin
                if (drdy) begin
                    pending <= 1'b0;
                    done    <= 1'b1;
                    data    <= do_in[15:4];
                end else if (cnt == TMO) begin
                    pending <= 1'b0;
                    err     <= 1'b1;
                end else begin
                    cnt <= cnt + 6'd1;
                end
            end
        end
    end

endmodule

// File: rtl/xadc_drp_sequencer.sv
// XADC DRP initiator: on eoc reads channel A then channel B and publishes 12-bit results.
// Define XADC_DRP_AVG_EN to publish the mean of every four successful pairs instead.
module xadc_drp_sequencer
    import xadc_pkg::*;
#(
    parameter logic [6:0]  ADDR_A  = XADC_VAUX3_ADDR,
    parameter logic [6:0]  ADDR_B  = XADC_VAUX11_ADDR,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             eoc,
    output logic             den,
    output logic             dwe,
    output logic [6:0]       daddr,
    input  logic             drdy,
    input  logic [15:0]      do_in,
    output logic [ADC_W-1:0] v1,
    output logic [ADC_W-1:0] v2,
    output logic             v_valid,
    output logic             busy,
    output logic             timeout_err
);

    state_t           state, next_state;
    logic             start;
    logic             port_done, port_err;
    logic [ADC_W-1:0] port_data;
    logic             fire;

    assign dwe = 1'b0;

    drp_read_port #(
        .TIMEOUT(TIMEOUT)
    ) u_port (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .drdy  (drdy),
        .do_in (do_in),
        .den   (den),
        .done  (port_done),
        .err   (port_err),
        .data  (port_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        busy       = 1'b0;
        v_valid    = 1'b0;
        case (state)
            S_IDLE: if (eoc) next_state = S_REQ_A;
            S_REQ_A: begin
                start      = 1'b1;
                busy       = 1'b1;
                next_state = S_WAIT_A;
            end
            S_WAIT_A: begin
                busy = 1'b1;
                if (port_done)     next_state = S_REQ_B;
                else if (port_err) next_state = S_IDLE;
            end
            S_REQ_B: begin
                start      = 1'b1;
                busy       = 1'b1;
                next_state = S_WAIT_B;
            end
            S_WAIT_B: begin
                busy = 1'b1;
                if (port_done)     next_state = S_DONE;
                else if (port_err) next_state = S_IDLE;
            end
            S_DONE: begin
                v_valid    = fire;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // daddr is loaded on entry to a REQ state and held through the matching WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            daddr       <= ADDR_A;
            timeout_err <= 1'b0;
        end else begin
            if (next_state == S_REQ_A)      daddr <= ADDR_A;
            else if (next_state == S_REQ_B) daddr <= ADDR_B;
            if (port_err)                             timeout_err <= 1'b1;
            else if (state == S_WAIT_B && port_done)  timeout_err <= 1'b0;
        end
    end

`ifdef XADC_DRP_AVG_EN
    logic [13:0] acc_a, acc_b, sum_b;
    logic [1:0]  scnt;

    assign sum_b = acc_b + 14'(port_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_a <= '0;
            acc_b <= '0;
            scnt  <= '0;
            fire  <= 1'b0;
            v1    <= '0;
            v2    <= '0;
        end else if (port_err) begin
            acc_a <= '0;
            acc_b <= '0;
            scnt  <= '0;
            fire  <= 1'b0;
        end else if (state == S_WAIT_A && port_done) begin
            acc_a <= acc_a + 14'(port_data);
        end else if (state == S_WAIT_B && port_done) begin
            if (scnt == 2'd3) begin
                v1    <= acc_a[13:2];
                v2    <= sum_b[13:2];
                acc_a <= '0;
                acc_b <= '0;
                scnt  <= '0;
                fire  <= 1'b1;
            end else begin
                acc_b <= sum_b;
                scnt  <= scnt + 2'd1;
                fire  <= 1'b0;
            end
        end
    end
`else
    assign fire = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= '0;
            v2 <= '0;
        end else begin
            if (state == S_WAIT_A && port_done) v1 <= port_data;
            if (state == S_WAIT_B && port_done) v2 <= port_data;
        end
    end
`endif

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Self-checking bench for xadc_drp_sequencer with a latency-programmable DRP responder.
module tb_xadc_drp_sequencer;

    localparam int TMO = 63;

    logic        clk = 1'b0;
    logic        rst_n, eoc, drdy;
    logic [15:0] do_in;
    logic        den, dwe, v_valid, busy, timeout_err;
    logic [6:0]  daddr;
    logic [11:0] v1, v2;

    always #5 clk = ~clk;

    xadc_drp_sequencer #(
        .ADDR_A  (7'h13),
        .ADDR_B  (7'h1B),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .eoc         (eoc),
        .den         (den),
        .dwe         (dwe),
        .daddr       (daddr),
        .drdy        (drdy),
        .do_in       (do_in),
        .v1          (v1),
        .v2          (v2),
        .v_valid     (v_valid),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Responder: answers each den after a per-address latency (0 = never answers).
    int          lat_a = 1, lat_b = 1;
    logic [15:0] dat_a = '0, dat_b = '0;
    int          cd = 0;
    logic [15:0] cd_data = '0;
    bit          inj = 0;
    logic [15:0] inj_data = '0;

    initial begin
        drdy  = 1'b0;
        do_in = '0;
        forever begin
            @(posedge clk);
            #1;
            drdy  = 1'b0;
            do_in = 16'($urandom);
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    drdy  = 1'b1;
                    do_in = cd_data;
                end
            end
            if (inj) begin
                drdy  = 1'b1;
                do_in = inj_data;
                inj   = 0;
            end
            if (den === 1'b1 && rst_n === 1'b1) begin
                if (daddr == 7'h13) begin cd = lat_a; cd_data = dat_a; end
                else                begin cd = lat_b; cd_data = dat_b; end
            end
        end
    end

    int         cyc = 0;
    int         den_n = 0, vv_n = 0, vv_cyc = 0;
    logic [6:0] den_addr[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (den === 1'b1) begin
            den_n++;
            den_addr.push_back(daddr);
        end
        if (v_valid === 1'b1) begin
            vv_n++;
            vv_cyc = cyc;
        end
    end

    // Reference model: what the published registers should hold after each pair.
    logic [11:0] m_v1 = '0, m_v2 = '0;
    logic        m_err = 1'b0;
    int          m_sa = 0, m_sb = 0, m_cnt = 0;

    function automatic bit answered(input int lat);
        return lat >= 1 && lat <= TMO + 1;
    endfunction

    task automatic model_reset();
        m_v1 = '0; m_v2 = '0; m_err = 1'b0;
        m_sa = 0;  m_sb = 0;  m_cnt = 0;
    endtask

    task automatic run_pair(input int la, input int lb, input logic [15:0] da,
                            input logic [15:0] db, input bit eoc2, input string tag);
        int t0, n, d0, v0, exp_dens;
        bit exp_valid;
        lat_a = la; lat_b = lb; dat_a = da; dat_b = db;
        d0 = den_n; v0 = vv_n;
        den_addr.delete();
        @(negedge clk); eoc = 1'b1; t0 = cyc;
        @(negedge clk); eoc = 1'b0;
        if (eoc2) begin
            @(negedge clk); eoc = 1'b1;
            @(negedge clk); eoc = 1'b0;
        end
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_finished"}, 32'(n < 400), 32'd1);
        repeat (3) @(negedge clk);

        exp_valid = 1'b0;
        if (!answered(la)) begin
            exp_dens = 1;
            m_err = 1'b1;
            m_sa = 0; m_sb = 0; m_cnt = 0;
        end else begin
            exp_dens = 2;
`ifdef XADC_DRP_AVG_EN
            m_sa += int'(da[15:4]);
`else
            m_v1 = da[15:4];
`endif
            if (!answered(lb)) begin
                m_err = 1'b1;
                m_sa = 0; m_sb = 0; m_cnt = 0;
            end else begin
                m_err = 1'b0;
`ifdef XADC_DRP_AVG_EN
                m_sb += int'(db[15:4]);
                m_cnt++;
                if (m_cnt == 4) begin
                    m_v1 = 12'(m_sa / 4);
                    m_v2 = 12'(m_sb / 4);
                    m_sa = 0; m_sb = 0; m_cnt = 0;
                    exp_valid = 1'b1;
                end
`else
                m_v2 = db[15:4];
                exp_valid = 1'b1;
`endif
            end
        end

        chk({tag, "_v1"}, 32'(v1), 32'(m_v1));
        chk({tag, "_v2"}, 32'(v2), 32'(m_v2));
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'(m_err));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_den_pulses"}, 32'(den_n - d0), 32'(exp_dens));
        chk({tag, "_v_valid_pulses"}, 32'(vv_n - v0), 32'(exp_valid));
        chk({tag, "_addr0"}, (den_addr.size() > 0) ? 32'(den_addr[0]) : 32'hDEAD, 32'h13);
        if (exp_dens == 2)
            chk({tag, "_addr1"}, (den_addr.size() > 1) ? 32'(den_addr[1]) : 32'hDEAD, 32'h1B);
        if (exp_valid)
            chk({tag, "_latency"}, 32'(vv_cyc - t0), 32'(5 + la + lb));
    endtask

    initial begin
        int d0, la, lb;
        rst_n = 1'b0;
        eoc   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_den", 32'(den), 32'd0);
        chk("rst_dwe", 32'(dwe), 32'd0);
        chk("rst_daddr", 32'(daddr), 32'h13);
        chk("rst_v1", 32'(v1), 32'd0);
        chk("rst_v2", 32'(v2), 32'd0);
        chk("rst_v_valid", 32'(v_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_pair(1, 1, 16'hABC0, 16'h1230, 1'b0, "basic");
        run_pair(1, 0, 16'h4560, 16'h7890, 1'b0, "tmo_b");
        run_pair(2, 3, 16'h1110, 16'h2220, 1'b0, "recover");
        run_pair(1, 2, 16'h3335, 16'h444A, 1'b1, "eoc_busy");
        run_pair(TMO + 1, 1, 16'h5550, 16'h6660, 1'b0, "edge_a");
        run_pair(3, TMO + 1, 16'h7770, 16'h8880, 1'b0, "edge_b");
        run_pair(TMO + 2, 1, 16'h9990, 16'hAAA0, 1'b0, "late_a");
        run_pair(2, 2, 16'hBBB0, 16'hCCC0, 1'b0, "clear");

        // drdy while idle must not be captured
        d0 = den_n;
        @(negedge clk); inj_data = 16'hFFF0; inj = 1;
        repeat (3) @(negedge clk);
        chk("idle_drdy_v1", 32'(v1), 32'(m_v1));
        chk("idle_drdy_v2", 32'(v2), 32'(m_v2));
        chk("idle_drdy_busy", 32'(busy), 32'd0);
        chk("idle_drdy_den", 32'(den_n - d0), 32'd0);

        for (int i = 0; i < 10; i++) begin
            la = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(6, 1));
            lb = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(6, 1));
            run_pair(la, lb, 16'($urandom), 16'($urandom), 1'($urandom), "rand");
        end

        // reset in WAIT_A, then a stale drdy
        lat_a = 0; lat_b = 0;
        @(negedge clk); eoc = 1'b1;
        @(negedge clk); eoc = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        d0 = den_n;
        inj_data = 16'hFFF0; inj = 1;
        repeat (4) @(negedge clk);
        chk("midrst_v1", 32'(v1), 32'd0);
        chk("midrst_v2", 32'(v2), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_den", 32'(den), 32'd0);
        chk("midrst_den_pulses", 32'(den_n - d0), 32'd0);
        chk("midrst_timeout_err", 32'(timeout_err), 32'd0);

        run_pair(1, 1, 16'h1000, 16'h2000, 1'b0, "post_rst");
`ifdef XADC_DRP_AVG_EN
        run_pair(1, 1, 16'h2000, 16'h0100, 1'b0, "avg2");
        run_pair(1, 1, 16'h3000, 16'h0200, 1'b0, "avg3");
        run_pair(1, 1, 16'h4000, 16'h0300, 1'b0, "avg4");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xadc_drp_sequencer.md
Name: xadc_drp_sequencer

Overview:
- DRP initiator for the on-chip XADC. It issues read requests that return the conversion words consumed downstream.
- On each end-of-conversion, it reads auxiliary channel A (0x13), then channel B (0x1B).
- It drives den/daddr, waits for drdy, and captures do_in[15:4] as 12-bit results.
- Sits between the XADC primitive and the fuzzy-logic input stage; replaces free-running address toggling with a proper request/response handshake.

Parameters:
- ADDR_A, 7'h13, DRP address of first channel (VAUX3).
- ADDR_B, 7'h1B, DRP address of second channel (VAUX11).
- TIMEOUT, 63, max clk cycles to wait for drdy after den (6-bit counter sufficient).

Ports:
- clk, input, 1, system clock (same clock as XADC DCLK).
- rst_n, input, 1, asynchronous active-low reset.
- eoc, input, 1, XADC end-of-conversion pulse; starts a read pair.
- den, output, 1, DRP enable, one-cycle pulse per request.
- dwe, output, 1, DRP write enable, tied 0 (read-only initiator).
- daddr, output, 7, DRP address.
- drdy, input, 1, DRP data ready.
- do_in, input, 16, DRP read data.
- v1, output, 12, latest channel-A result.
- v2, output, 12, latest channel-B result.
- v_valid, output, 1, one-cycle pulse when both v1 and v2 updated for a pair.
- busy, output, 1, high from eoc acceptance until the pair completes or aborts.
- timeout_err, output, 1, sticky; set on drdy timeout, cleared by reset or next successful pair.

Behaviour:
- Reset values: den=0, dwe=0, daddr=ADDR_A, v1=0, v2=0, v_valid=0, busy=0, timeout_err=0, state=IDLE, counter=0.
- States: IDLE, REQ_A, WAIT_A, REQ_B, WAIT_B, DONE.
- IDLE:
  - eoc=1 -> REQ_A, busy=1.
  - Otherwise stay.
- REQ_A:
  - den=1 for exactly one cycle, daddr=ADDR_A; counter cleared.
  - -> WAIT_A.
- WAIT_A:
  - drdy=1 -> v1<=do_in[15:4], -> REQ_B.
  - Counter==TIMEOUT without drdy -> timeout_err=1, busy=0, -> IDLE; v1/v2 unchanged.
- REQ_B / WAIT_B: identical, using ADDR_B and v2. Success -> DONE.
- DONE:
  - v_valid=1 for one cycle, timeout_err=0, busy=0.
  - -> IDLE.
- Latency: eoc to v_valid = 5 cycles + two drdy latencies (minimum 7 cycles when drdy returns the cycle after den).
- daddr holds its value through the WAIT state; it changes only in the REQ states.
- eoc while busy is ignored (no queuing). eoc in the DONE cycle is also ignored.
- drdy in IDLE, REQ_A or REQ_B is ignored, with no capture.
- drdy on the same cycle the counter reaches TIMEOUT: drdy wins, and the data is captured.
- Never more than one outstanding den; den never asserted in WAIT states.
- Reset mid-transaction: immediate return to IDLE with reset values; a late drdy after reset is ignored.

Optional Feature:
- Macro: XADC_DRP_AVG_EN.
- Defined:
  - Per-channel 14-bit accumulator sums 4 consecutive successful samples.
  - v1/v2 are updated with sum>>2 on every 4th pair.
  - v_valid pulses only on those pairs.
  - A timeout clears both accumulators and the 2-bit sample count.
  - Reset clears the accumulators.
- Undefined: every successful pair updates v1/v2 directly and pulses v_valid; no accumulator logic is synthesised.

Decomposition:
- Shared package xadc_pkg holds:
  - State encoding typedef (3-bit enum).
  - XADC_VAUX3_ADDR=7'h13 and XADC_VAUX11_ADDR=7'h1B.
  - Result width constant ADC_W=12.
- One sub-module is natural: drp_read_port.
  - Single-request den pulse, wait for drdy, and timeout counter.
  - Returns data and done/err strobes.
  - Instantiated once and sequenced by the top FSM.

Test Plan:
- Basic pair: eoc pulse; responder returns 16'hABC0 for 0x13 and 16'h1230 for 0x1B, each 1 cycle after den -> v1=12'hABC, v2=12'h123, v_valid one pulse, exactly two den pulses with daddr 0x13 then 0x1B.
- Timeout: responder silent on 0x1B -> after 63 WAIT cycles timeout_err=1, busy=0, v2 unchanged, v_valid never asserted; next good pair clears timeout_err.
- eoc while busy: second eoc 2 cycles after first -> still only two den pulses; one v_valid.
- Boundary drdy: drdy arrives in the cycle counter==TIMEOUT -> data captured, timeout_err stays 0.
- Reset mid-WAIT_A: rst_n low for 1 cycle, then late drdy with 16'hFFF0 -> v1 stays 0, state IDLE, den low.
- XADC_DRP_AVG_EN: four pairs with channel A = 0x100,0x200,0x300,0x400 (<<4) -> single v_valid after 4th pair, v1=12'h280.
